mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported memory between the fetch port and the load/store port.
// Latency : request seen in IDLE cycle t -> ack in cycle t+MEM_LATENCY+1; one access per MEM_LATENCY+2 cycles.
// Backpr. : requesters hold req/addr/wdata/we until ack; halted blocks new grants, in-flight access completes.
//
// Ports:
//   clk, rst_b                 clock (rising edge), asynchronous active-low reset
//   halted                     suppresses new grants while high
//   if_req/if_addr             fetch request; if_ack/if_rdata one-cycle completion
//   d_req/d_we/d_addr/d_wdata  load/store request; d_ack/d_rdata one-cycle completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-ported memory interface
//   busy                       high whenever an access is in progress
//   grant_is_data              high while the current access belongs to the data port
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            halted,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic            grant_is_data
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_starve_cnt;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_we;
  logic              r_owner;     // 1 = data port owns the access

  logic              w_grant;
  logic              w_pick_data;

  // Arbitration only matters in IDLE; a fetch that has watched STARVE_LIMIT
  // data grants go by wins the next contested slot.
  assign w_grant     = (r_state == IDLE) && !halted && (if_req || d_req);
  assign w_pick_data = d_req && !(if_req && (r_starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if_ack        = 1'b0;
    if_rdata      = '0;
    d_ack         = 1'b0;
    d_rdata       = '0;
    busy          = (r_state != IDLE);
    grant_is_data = (r_state != IDLE) && r_owner;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        // The counter is still at its load value only on the first ACCESS cycle.
        if (r_cnt == CNT_INIT) begin
          mem_en = 1'b1;
          mem_we = r_we;
        end
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (r_owner) begin
          d_ack   = 1'b1;
          d_rdata = r_we ? '0 : mem_rdata;
        end else begin
          if_ack   = 1'b1;
          if_rdata = mem_rdata;
        end
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt        <= '0;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_owner      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_cnt   <= CNT_INIT;
            r_owner <= w_pick_data;
            if (w_pick_data) begin
              r_addr  <= d_addr;
              r_wdata <= d_wdata;
              r_we    <= d_we;
            end else begin
              r_addr  <= if_addr;
              r_wdata <= '0;
              r_we    <= 1'b0;
            end
            // Count only data grants that actually made a fetch wait.
            if (w_pick_data && if_req) begin
              if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter with a memory responder and a grant-timeline model.
// Latency : expectations derived from grant cycles: mem_en at g+1, ack at g+MEM_LATENCY+1, idle at g+MEM_LATENCY+2.
// Backpr. : requesters hold their fields until the model-predicted ack, then retire or issue a new request.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int ML   = 2;
  localparam int SL   = 3;

  logic            clk     = 1'b0;
  logic            rst_b   = 1'b1;
  logic            halted  = 1'b0;
  logic            if_req  = 1'b0;
  logic [XLEN-1:0] if_addr = '0;
  logic            d_req   = 1'b0;
  logic            d_we    = 1'b0;
  logic [XLEN-1:0] d_addr  = '0;
  logic [XLEN-1:0] d_wdata = '0;
  logic [XLEN-1:0] mem_rdata;
  logic            if_ack, d_ack, mem_en, mem_we, busy, grant_is_data;
  logic [XLEN-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_at = -100;
  logic [31:0] rd_val  = '0;
  logic [31:0] garbage = '0;

  logic [31:0] sim_mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];

  // Grant timeline used to derive expected outputs.
  int          g_n;
  int          g_k  [8];
  bit          g_d  [8];
  bit          g_we [8];
  logic [31:0] g_a  [8];
  logic [31:0] g_wd [8];

  logic [5:0]   obs_ctl;
  logic [127:0] obs_dat;
  assign obs_ctl = {busy, mem_en, mem_we, if_ack, d_ack, grant_is_data};
  assign obs_dat = {mem_addr, mem_wdata, if_rdata, d_rdata};

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LATENCY(ML), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_is_data(grant_is_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    garbage <= $urandom;
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  // Memory with fixed read latency; returns noise outside the valid cycle.
  assign mem_rdata = (cyc == rd_at) ? rd_val : garbage;
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      rd_val = sim_mem.exists(mem_addr) ? sim_mem[mem_addr] : init_word(mem_addr);
      if (mem_we === 1'b1) sim_mem[mem_addr] = mem_wdata;
      rd_at = cyc + ML;
    end
  end

  function automatic void add_grant(input int k, input bit d, input bit we,
                                    input logic [31:0] a, input logic [31:0] wd);
    g_k[g_n[2:0]]  = k;
    g_d[g_n[2:0]]  = d;
    g_we[g_n[2:0]] = we;
    g_a[g_n[2:0]]  = a;
    g_wd[g_n[2:0]] = wd;
    g_n++;
  endfunction

  function automatic logic [5:0] exp_ctl(input int k);
    logic b, e, w, ia, da, gd;
    {b, e, w, ia, da, gd} = 6'b0;
    for (int i = 0; i < g_n; i++) begin
      if (k > g_k[i[2:0]] && k <= g_k[i[2:0]] + ML + 1) begin
        b  = 1'b1;
        gd = gd | g_d[i[2:0]];
      end
      if (k == g_k[i[2:0]] + 1) begin
        e = 1'b1;
        w = g_we[i[2:0]];
      end
      if (k == g_k[i[2:0]] + ML + 1) begin
        ia = ia | !g_d[i[2:0]];
        da = da | g_d[i[2:0]];
      end
    end
    return {b, e, w, ia, da, gd};
  endfunction

  // Fields: addr, wdata, if_rdata, d_rdata. Address/wdata are not defined
  // during the response cycle, and wdata means nothing for a fetch.
  function automatic logic [127:0] exp_dat(input int k, output logic [127:0] m);
    logic [31:0] a, wd, ir, dr;
    a = '0; wd = '0; ir = '0; dr = '0;
    m = '1;
    for (int i = 0; i < g_n; i++) begin
      if (k > g_k[i[2:0]] && k <= g_k[i[2:0]] + ML) begin
        a = g_a[i[2:0]];
        if (g_d[i[2:0]]) wd = g_wd[i[2:0]];
        else m[95:64] = '0;
      end
      if (k == g_k[i[2:0]] + ML + 1) begin
        m[127:64] = '0;
        if (!g_d[i[2:0]]) ir = exp_read(g_a[i[2:0]]);
        else if (!g_we[i[2:0]]) dr = exp_read(g_a[i[2:0]]);
      end
    end
    return {a, wd, ir, dr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_b = 1'b0;
    if_req = 1'b1;
    d_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total += 2;
      if (obs_ctl !== 6'b0) begin bad++; $display("FAIL reset ctl k=%0d got=%b exp=0", k, obs_ctl); end
      if (obs_dat !== 128'b0) begin bad++; $display("FAIL reset dat k=%0d got=%h exp=0", k, obs_dat); end
      tick();
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    rst_b  = 1'b1;
    @(negedge clk);
    total += 2;
    if (obs_ctl !== 6'b0) begin bad++; $display("FAIL reset_rel ctl got=%b exp=0", obs_ctl); end
    if (obs_dat !== 128'b0) begin bad++; $display("FAIL reset_rel dat got=%h exp=0", obs_dat); end
    tick();
  endtask

  task automatic test_lone_fetch();
    logic [127:0] m, ed;
    logic [5:0]   ec;
    g_n = 0;
    add_grant(0, 1'b0, 1'b0, 32'h100, 32'h0);
    sim_mem[32'h100] = 32'h8C22_0004;
    exp_mem[32'h100] = 32'h8C22_0004;
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k <= 5; k++) begin
      if (k == 4) if_req = 1'b0;
      @(negedge clk);
      ec = exp_ctl(k); ed = exp_dat(k, m); total += 2;
      if (obs_ctl !== ec) begin bad++; $display("FAIL lone_fetch ctl k=%0d got=%b exp=%b", k, obs_ctl, ec); end
      if ((obs_dat & m) !== (ed & m)) begin bad++; $display("FAIL lone_fetch dat k=%0d got=%h exp=%h", k, obs_dat & m, ed & m); end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic [127:0] m, ed;
    logic [5:0]   ec;
    g_n = 0;
    add_grant(0, 1'b1, 1'b0, 32'h200, 32'h0);
    add_grant(4, 1'b0, 1'b0, 32'h300, 32'h0);
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
    for (int k = 0; k <= 8; k++) begin
      if (k == 4) d_req = 1'b0;
      if (k == 8) if_req = 1'b0;
      @(negedge clk);
      ec = exp_ctl(k); ed = exp_dat(k, m); total += 2;
      if (obs_ctl !== ec) begin bad++; $display("FAIL simultaneous ctl k=%0d got=%b exp=%b", k, obs_ctl, ec); end
      if ((obs_dat & m) !== (ed & m)) begin bad++; $display("FAIL simultaneous dat k=%0d got=%h exp=%h", k, obs_dat & m, ed & m); end
      tick();
    end
  endtask

  task automatic test_starvation();
    logic [127:0] m, ed;
    logic [5:0]   ec;
    g_n = 0;
    add_grant(0,  1'b1, 1'b0, 32'h400, 32'h0);
    add_grant(4,  1'b1, 1'b0, 32'h404, 32'h0);
    add_grant(8,  1'b1, 1'b0, 32'h408, 32'h0);
    add_grant(12, 1'b0, 1'b0, 32'h800, 32'h0);
    add_grant(16, 1'b1, 1'b0, 32'h40C, 32'h0);
    add_grant(20, 1'b0, 1'b0, 32'h804, 32'h0);
    if_req = 1'b1; if_addr = 32'h800;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = 32'h0;
    for (int k = 0; k <= 24; k++) begin
      if (k == 4)  d_addr = 32'h404;
      if (k == 8)  d_addr = 32'h408;
      if (k == 12) d_addr = 32'h40C;
      if (k == 16) if_addr = 32'h804;
      if (k == 20) d_req = 1'b0;
      if (k == 24) if_req = 1'b0;
      @(negedge clk);
      ec = exp_ctl(k); ed = exp_dat(k, m); total += 2;
      if (obs_ctl !== ec) begin bad++; $display("FAIL starvation ctl k=%0d got=%b exp=%b", k, obs_ctl, ec); end
      if ((obs_dat & m) !== (ed & m)) begin bad++; $display("FAIL starvation dat k=%0d got=%h exp=%h", k, obs_dat & m, ed & m); end
      tick();
    end
  endtask

  task automatic test_store();
    logic [127:0] m, ed;
    logic [5:0]   ec;
    g_n = 0;
    add_grant(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    add_grant(4, 1'b1, 1'b0, 32'h40, 32'h0);
    exp_mem[32'h40] = 32'hDEAD_BEEF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k <= 8; k++) begin
      if (k == 4) begin d_we = 1'b0; d_wdata = 32'h0; end
      if (k == 8) d_req = 1'b0;
      @(negedge clk);
      ec = exp_ctl(k); ed = exp_dat(k, m); total += 2;
      if (obs_ctl !== ec) begin bad++; $display("FAIL store ctl k=%0d got=%b exp=%b", k, obs_ctl, ec); end
      if ((obs_dat & m) !== (ed & m)) begin bad++; $display("FAIL store dat k=%0d got=%h exp=%h", k, obs_dat & m, ed & m); end
      tick();
    end
  endtask

  task automatic test_halted();
    logic [127:0] m, ed;
    logic [5:0]   ec;
    g_n = 0;
    add_grant(6,  1'b0, 1'b0, 32'h500, 32'h0);
    add_grant(16, 1'b1, 1'b0, 32'h600, 32'h1234_5678);
    halted = 1'b1; if_req = 1'b1; if_addr = 32'h500;
    for (int k = 0; k <= 20; k++) begin
      if (k == 6) halted = 1'b0;
      if (k == 7) begin
        halted = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_wdata = 32'h1234_5678;
      end
      if (k == 10) if_req = 1'b0;
      if (k == 16) halted = 1'b0;
      if (k == 20) d_req = 1'b0;
      @(negedge clk);
      ec = exp_ctl(k); ed = exp_dat(k, m); total += 2;
      if (obs_ctl !== ec) begin bad++; $display("FAIL halted ctl k=%0d got=%b exp=%b", k, obs_ctl, ec); end
      if ((obs_dat & m) !== (ed & m)) begin bad++; $display("FAIL halted dat k=%0d got=%h exp=%h", k, obs_dat & m, ed & m); end
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    logic [127:0] m, ed;
    logic [5:0]   ec;
    g_n = 0;
    add_grant(0, 1'b0, 1'b0, 32'h700, 32'h0);
    if_req = 1'b1; if_addr = 32'h700;
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) begin
        #1 rst_b = 1'b0;
        #1;
        total += 2;
        if (obs_ctl !== 6'b0) begin bad++; $display("FAIL reset_mid ctl got=%b exp=0", obs_ctl); end
        if (obs_dat !== 128'b0) begin bad++; $display("FAIL reset_mid dat got=%h exp=0", obs_dat); end
        g_n = 0;
        add_grant(4, 1'b0, 1'b0, 32'h700, 32'h0);
      end
      if (k == 4) rst_b = 1'b1;
      if (k == 8) if_req = 1'b0;
      @(negedge clk);
      ec = exp_ctl(k); ed = exp_dat(k, m); total += 2;
      if (obs_ctl !== ec) begin bad++; $display("FAIL reset_mid ctl k=%0d got=%b exp=%b", k, obs_ctl, ec); end
      if ((obs_dat & m) !== (ed & m)) begin bad++; $display("FAIL reset_mid dat k=%0d got=%h exp=%h", k, obs_dat & m, ed & m); end
      tick();
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 + ($urandom_range(0, 7) << 2);
  endfunction

  // Transaction-level reference: an access granted at cycle g occupies the
  // port until g+ML+2; priority and starvation follow the arbitration rules.
  task automatic test_random();
    logic [127:0] m, ed;
    logic [5:0]   ec;
    int free_at = 0;
    int starve  = 0;
    int gk      = -100;
    bit gd;
    g_n = 0;
    for (int k = 0; k < 1500; k++) begin
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) halted = ~halted;
      if (k >= free_at && !halted && (if_req || d_req)) begin
        gd = d_req && !(if_req && starve == SL);
        if (gd && if_req) starve = (starve < SL) ? starve + 1 : SL;
        else starve = 0;
        g_n = 0;
        if (gd) begin
          add_grant(k, 1'b1, d_we, d_addr, d_wdata);
          if (d_we) exp_mem[d_addr] = d_wdata;
        end else begin
          add_grant(k, 1'b0, 1'b0, if_addr, 32'h0);
        end
        gk = k;
        free_at = k + ML + 2;
      end
      @(negedge clk);
      ec = exp_ctl(k); ed = exp_dat(k, m); total += 2;
      if (obs_ctl !== ec) begin bad++; $display("FAIL random ctl k=%0d got=%b exp=%b", k, obs_ctl, ec); end
      if ((obs_dat & m) !== (ed & m)) begin bad++; $display("FAIL random dat k=%0d got=%h exp=%h", k, obs_dat & m, ed & m); end
      tick();
      // The owner has just seen its ack: retire or present a fresh request.
      if (k == gk + ML + 1) begin
        if (gd) begin
          if ($urandom_range(0, 1) == 0) d_req = 1'b0;
          else begin d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom; end
        end else begin
          if ($urandom_range(0, 1) == 0) if_req = 1'b0;
          else if_addr = rnd_addr();
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    halted = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_halted();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
